// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, decode-resolved
// control-flow flushes, memory-wait freeze with watchdog, and a stall-cycle counter.
module hazard_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             MemReadEnE,
    input  logic             PCSrcD,
    input  logic             JalD,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             PCRedirectEn,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } stateT;

    stateT             state;
    logic [WCNT_W-1:0] waitCnt;

    logic memWait;
    logic timeoutNow;
    logic memStall;
    logic loadUse;
    logic ctrlFlow;

    assign memWait    = (state == MEM_WAIT) | ((state == RUN) & MemReqM & ~MemReadyM);
    // The timeout cycle is itself the MAX_WAIT-th wait cycle, so it releases instead of stalling.
    assign timeoutNow = (state == MEM_WAIT) & ~MemReadyM & (waitCnt == WCNT_W'(MAX_WAIT - 1));
    assign memStall   = memWait & ~((state == MEM_WAIT) & MemReadyM) & ~timeoutNow;
    assign loadUse    = MemReadEnE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign ctrlFlow   = PCSrcD | JalD;

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (loadUse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (ctrlFlow) begin
            FlushD = 1'b1;
        end
        PCRedirectEn = ctrlFlow & ~StallD & ~rst;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            waitCnt     <= '0;
            MemTimeout  <= 1'b0;
            StallCycles <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state   <= MEM_WAIT;
                        waitCnt <= WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM || timeoutNow) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + WCNT_W'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase

            if (timeoutNow) begin
                MemTimeout <= 1'b1;
            end

            if (StallF && (StallCycles != {CNT_W{1'b1}})) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
        end
    end

endmodule
